ecc_scrub_ctrl: RTL
===================

Name: ecc_scrub_ctrl

Overview:
- Background scrubber and port arbiter for the ECC-protected memory.
- Walks every address, reads the codeword and waits for the ECC decode-control verdict (single/double vs triple error). It writes back corrected data for correctable words and logs uncorrectable ones.
- Shares the single memory port with a host requester. The host has priority except when a scrub is overdue.

Parameters:
- ADDR_W, 10, memory address width.
- DEPTH, 1024, number of words scrubbed per pass (DEPTH <= 2**ADDR_W).
- SCRUB_INTERVAL, 256, idle cycles between scrub reads (>= 1).
- DEC_TIMEOUT, 8, maximum cycles to wait for dec_valid after the read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- scrub_en  in  1  enable background scrubbing
- host_req  in  1  host wants the memory port (level)
- host_addr  in  ADDR_W  host address
- host_gnt  out  1  host owns the port this cycle
- mem_rd  out  1  scrub read strobe (1 cycle)
- mem_wr  out  1  scrub write-back strobe (1 cycle)
- mem_addr  out  ADDR_W  host_addr when host_gnt, else scrub address
- dec_valid  in  1  decoder verdict valid (1-cycle pulse)
- dec_single_double  in  1  correctable error flagged by decoder
- dec_triple  in  1  uncorrectable error flagged by decoder
- wb_sel  out  1  route corrected data to memory write data
- ue_clr  in  1  clear uncorrectable halt (used only with macro)
- corr_cnt  out  16  corrected-error count, saturating
- uncorr_cnt  out  16  uncorrectable-error count, saturating
- uncorr_addr  out  ADDR_W  address of the most recent uncorrectable or timed-out word
- uncorr_irq  out  1  1-cycle pulse per uncorrectable or timeout
- pass_done  out  1  1-cycle pulse when the address wraps
- busy  out  1  FSM not in IDLE/WAIT

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values: all outputs 0. Scrub address 0, interval counter 0, state IDLE.
- States: IDLE, WAIT, READ, DECODE, WB, LOG.
- IDLE -> WAIT when scrub_en=1. Interval counter loads SCRUB_INTERVAL-1.
- WAIT: counter decrements each cycle. At 0, overdue=1. Move to READ when overdue and (host_req=0 or overdue has been set for at least 1 full cycle). A host therefore delays a due scrub by at most 1 cycle. scrub_en=0 in WAIT -> IDLE.
- READ: mem_rd=1 and mem_addr=scrub address, for exactly 1 cycle. host_gnt=0. Next state DECODE with the timeout counter cleared.
- DECODE: hold until dec_valid.
  - dec_triple=1 -> LOG; dec_triple has priority if both flags are set.
  - else dec_single_double=1 -> WB.
  - else (clean word) -> advance the address, then WAIT.
  - No dec_valid within DEC_TIMEOUT cycles -> LOG, counted as uncorrectable.
- WB: mem_wr=1 and wb_sel=1 for 1 cycle. corr_cnt increments, saturating at 16'hFFFF. Then advance the address and go to WAIT.
- LOG: uncorr_cnt increments (saturating), uncorr_addr = scrub address, uncorr_irq pulses. No write-back. Advance the address, then WAIT.
- Address advance: DEPTH-1 wraps to 0 with a pass_done pulse in the same cycle.
- host_gnt = host_req && state in {IDLE, WAIT} && not the cycle READ is being entered. Combinational. READ/DECODE/WB/LOG form an atomic RMW, and the host is never granted during it.
- scrub_en falling mid-RMW: the sequence completes, then the FSM goes to IDLE. The address is retained and resumes on re-enable.
- Every return to WAIT reloads the interval counter and clears overdue.
- Asynchronous reset mid-operation: immediate return to reset values. Strobes drop without completing.

Optional Feature:
- Macro: ECC_SCRUB_HALT_ON_UE_EN.
- Defined: LOG transitions to a HALT state instead of WAIT. In HALT, busy=0, the host is always grantable and no scrub reads are issued. ue_clr=1 releases HALT to WAIT. The address has already advanced past the bad word.
- Undefined: no HALT state, ue_clr is ignored and scrubbing continues after LOG.

Test Plan:
- SCRUB_INTERVAL=4, clean words (dec_valid after 2 cycles, flags 0) -> mem_rd every 4+1+2 cycles; address 0,1,2...; DEPTH=4 gives pass_done on the 0->wrap step; counters stay 0.
- dec_single_double=1 at address 5 -> mem_wr=1 and wb_sel=1 for 1 cycle at mem_addr 5; corr_cnt=1; no uncorr_irq.
- dec_single_double=1 and dec_triple=1 together at address 7 -> no mem_wr; uncorr_cnt=1, uncorr_addr=7, one uncorr_irq pulse. With the macro, FSM stays halted until ue_clr.
- dec_valid never asserted, DEC_TIMEOUT=8 -> LOG exactly 8 cycles after entering DECODE; uncorr_cnt=1.
- host_req held high continuously -> host_gnt=1 except for at most 1 cycle of delay plus the RMW window; scrub still progresses. host_gnt=0 throughout READ..WB; mem_addr=host_addr whenever host_gnt=1.
- rst_n low during WB -> mem_wr=0 immediately, counters=0, state IDLE; after release with scrub_en=1, scrubbing restarts at address 0.

Source files
------------

// File: rtl/ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrub_ctrl
// Purpose  : Background ECC scrubber with host/scrub arbitration of one port.
//            Optional build macro ECC_SCRUB_HALT_ON_UE_EN: halt after an
//            uncorrectable word until ue_clr.
// Revision : 1.0  initial release
// ============================================================================
module ecc_scrub_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int SCRUB_INTERVAL = 256,
    parameter int DEC_TIMEOUT    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scrub_en,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              dec_valid,
    input  logic              dec_single_double,
    input  logic              dec_triple,
    output logic              wb_sel,
    input  logic              ue_clr,
    output logic [15:0]       corr_cnt,
    output logic [15:0]       uncorr_cnt,
    output logic [ADDR_W-1:0] uncorr_addr,
    output logic              uncorr_irq,
    output logic              pass_done,
    output logic              busy
);

    localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam int TMO_W = $clog2(DEC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  c_reload    = CNT_W'(SCRUB_INTERVAL - 1);
    localparam logic [TMO_W-1:0]  c_tmo_last  = TMO_W'(DEC_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_READ   = 3'd2,
        S_DECODE = 3'd3,
        S_WB     = 3'd4,
        S_LOG    = 3'd5
`ifdef ECC_SCRUB_HALT_ON_UE_EN
        ,
        S_HALT   = 3'd6
`endif
    } state_t;

    state_t            r_state;
    state_t            w_next;
    state_t            w_resume;
    logic [CNT_W-1:0]  r_ivl;
    logic              r_overdue;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_corr;
    logic [15:0]       r_uncorr;
    logic [ADDR_W-1:0] r_uaddr;
    logic              w_due;
    logic              w_go;
    logic              w_start;
    logic              w_advance;
    logic              w_port_free;

`ifndef ECC_SCRUB_HALT_ON_UE_EN
    logic w_unused_ue_clr;
    assign w_unused_ue_clr = ue_clr;
`endif

    // A host only holds off a due scrub for the single cycle it first becomes due.
    assign w_due    = (r_ivl == '0);
    assign w_go     = w_due && (!host_req || r_overdue);
    assign w_resume = scrub_en ? S_WAIT : S_IDLE;

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scrub_en) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!scrub_en) begin
                    w_next = S_IDLE;
                end else if (w_go) begin
                    w_next  = S_READ;
                    w_start = 1'b1;
                end
            end
            S_READ: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (dec_valid) begin
                    if (dec_triple) begin
                        w_next = S_LOG;
                    end else if (dec_single_double) begin
                        w_next = S_WB;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = w_resume;
                    end
                end else if (r_tmo == c_tmo_last) begin
                    w_next = S_LOG;
                end
            end
            S_WB: begin
                w_advance = 1'b1;
                w_next    = w_resume;
            end
            S_LOG: begin
                w_advance = 1'b1;
`ifdef ECC_SCRUB_HALT_ON_UE_EN
                w_next    = S_HALT;
`else
                w_next    = w_resume;
`endif
            end
`ifdef ECC_SCRUB_HALT_ON_UE_EN
            S_HALT: begin
                if (ue_clr) w_next = S_WAIT;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ivl     <= '0;
            r_overdue <= 1'b0;
            r_tmo     <= '0;
            r_addr    <= '0;
            r_corr    <= '0;
            r_uncorr  <= '0;
            r_uaddr   <= '0;
        end else begin
            r_state <= w_next;

            if (w_next == S_WAIT && r_state != S_WAIT) begin
                r_ivl <= c_reload;
            end else if (r_state == S_WAIT && r_ivl != '0) begin
                r_ivl <= r_ivl - 1'b1;
            end

            if (r_state == S_WAIT && w_next == S_WAIT) begin
                r_overdue <= w_due;
            end else begin
                r_overdue <= 1'b0;
            end

            if (r_state == S_READ) begin
                r_tmo <= '0;
            end else if (r_state == S_DECODE && r_tmo != c_tmo_last) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_advance) begin
                r_addr <= (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;
            end

            if (r_state == S_WB && r_corr != 16'hFFFF) begin
                r_corr <= r_corr + 16'd1;
            end

            if (r_state == S_LOG) begin
                r_uaddr <= r_addr;
                if (r_uncorr != 16'hFFFF) r_uncorr <= r_uncorr + 16'd1;
            end
        end
    end

`ifdef ECC_SCRUB_HALT_ON_UE_EN
    assign w_port_free = (r_state == S_IDLE) || (r_state == S_WAIT) || (r_state == S_HALT);
`else
    assign w_port_free = (r_state == S_IDLE) || (r_state == S_WAIT);
`endif

    assign host_gnt    = host_req && w_port_free && !w_start;
    assign mem_rd      = (r_state == S_READ);
    assign mem_wr      = (r_state == S_WB);
    assign wb_sel      = (r_state == S_WB);
    assign mem_addr    = host_gnt ? host_addr : r_addr;
    assign uncorr_irq  = (r_state == S_LOG);
    assign pass_done   = w_advance && (r_addr == c_last_addr);
    assign busy        = !w_port_free;
    assign corr_cnt    = r_corr;
    assign uncorr_cnt  = r_uncorr;
    assign uncorr_addr = r_uaddr;

endmodule
`default_nettype wire
